// File: rtl/std_div_radix_pipe_pkg.sv
// std_div_pkg: shared types and helpers for the radix-2^k restoring divider.
//   div_state_t  : controller states (IDLE, RUN, FIX, DONE)
//   magnitude()  : two's-complement absolute value of a w-bit value held in 64 bits
//   cnt_width()  : iteration counter width, $clog2(width/bits_per_cycle), minimum 1
package std_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Low w bits of the result are the magnitude; the caller truncates.
  function automatic logic [63:0] magnitude(input logic [63:0] v, input int w,
                                            input bit is_signed);
    logic [5:0] idx;
    idx = 6'(w - 1);
    if (is_signed && v[idx]) return ~v + 64'd1;
    return v;
  endfunction

  function automatic int cnt_width(input int w, input int bpc);
    int n;
    n = w / bpc;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/std_div_radix_pipe_if.sv
// Request/result bundle for std_div_radix_pipe.
//   go            : request, held by the caller until done is seen
//   left / right  : dividend / divisor, sampled on the start cycle only
//   out_quotient  : registered quotient, valid with done, held until next start
//   out_remainder : registered remainder, valid with done, held until next start
//   done          : one-cycle completion pulse
// master = caller side, slave = divider side.
interface std_div_radix_pipe_if #(
  parameter int width = 32
);
  logic             go;
  logic [width-1:0] left;
  logic [width-1:0] right;
  logic [width-1:0] out_quotient;
  logic [width-1:0] out_remainder;
  logic             done;

  modport master (output go, left, right, input out_quotient, out_remainder, done);
  modport slave  (input go, left, right, output out_quotient, out_remainder, done);
endinterface

// File: rtl/std_div_radix_pipe_step.sv
// std_div_radix_step: bits_per_cycle restoring division steps, purely combinational.
//   i_rem     : partial remainder (width+1 bits)
//   i_bits    : next dividend bits, MSB first (bit bits_per_cycle-1 consumed first)
//   i_divisor : divisor magnitude
//   o_rem     : updated partial remainder
//   o_q       : quotient bits resolved by this chain, MSB first
module std_div_radix_step #(
  parameter int width          = 32,
  parameter int bits_per_cycle = 1
) (
  input  logic [width:0]          i_rem,
  input  logic [bits_per_cycle-1:0] i_bits,
  input  logic [width-1:0]        i_divisor,
  output logic [width:0]          o_rem,
  output logic [bits_per_cycle-1:0] o_q
);

  always_comb begin
    logic [width:0] w_acc;
    w_acc = i_rem;
    o_q   = '0;
    for (int k = bits_per_cycle - 1; k >= 0; k--) begin
      w_acc = (w_acc << 1) | {{width{1'b0}}, i_bits[k]};
      if (w_acc >= {1'b0, i_divisor}) begin
        w_acc  = w_acc - {1'b0, i_divisor};
        o_q[k] = 1'b1;
      end
    end
    o_rem = w_acc;
  end

endmodule

// File: rtl/std_div_radix_pipe.sv
// std_div_radix_pipe: iterative restoring divider, bits_per_cycle quotient bits per clock,
// quotient and remainder produced together with fixed latency (done N+1 edges after start,
// N = width/bits_per_cycle).
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : std_div_radix_pipe_if.slave (go/left/right in, out_quotient/out_remainder/done out)
// Parameters: width (>=2, <=64), bits_per_cycle (divides width), signed_mode (0 unsigned,
// 1 two's complement, truncating).
// Optional build macro DIV_SELF_CHECK_EN: compares each result against behavioural / and %
// in the DONE cycle (zero divisor and signed overflow excluded) and reports $error on mismatch.
//
// state | meaning
// IDLE  | waiting for go; operands latched on the start edge
// RUN   | bits_per_cycle restoring steps per clock, counter counts down to 0
// FIX   | sign correction / special cases, outputs registered
// DONE  | done high for one cycle, then back to IDLE
module std_div_radix_pipe
  import std_div_pkg::*;
#(
  parameter int width          = 32,
  parameter int bits_per_cycle = 1,
  parameter int signed_mode    = 0
) (
  input logic clk,
  input logic reset,
  std_div_radix_pipe_if.slave bus
);

  localparam int N  = width / bits_per_cycle;
  localparam int CW = cnt_width(width, bits_per_cycle);
  localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
  localparam logic [width-1:0] MOST_NEG = {1'b1, {(width - 1){1'b0}}};

  if (width < 2 || width > 64) begin : g_bad_width
    $error("std_div_radix_pipe: width must be in 2..64");
  end
  if (bits_per_cycle < 1 || (width % bits_per_cycle) != 0) begin : g_bad_bpc
    $error("std_div_radix_pipe: bits_per_cycle must divide width");
  end

  div_state_t r_state, w_next;

  logic [CW-1:0]    r_cnt;
  logic [width:0]   r_rem;
  logic [width-1:0] r_dvd, r_dsr, r_q, r_quo, r_rmd;
  logic             r_neg_l, r_neg_r, r_dz, r_ovf;

  logic             w_neg_l, w_neg_r;
  logic [width-1:0] w_mag_l, w_mag_r;
  logic [width:0]   w_step_rem;
  logic [bits_per_cycle-1:0] w_step_q;
  logic [width-1:0] w_fix_q, w_fix_r;

  assign w_neg_l = (signed_mode != 0) && bus.left[width-1];
  assign w_neg_r = (signed_mode != 0) && bus.right[width-1];
  assign w_mag_l = width'(magnitude(64'(bus.left), width, signed_mode != 0));
  assign w_mag_r = width'(magnitude(64'(bus.right), width, signed_mode != 0));

  std_div_radix_step #(
    .width         (width),
    .bits_per_cycle(bits_per_cycle)
  ) u_step (
    .i_rem    (r_rem),
    .i_bits   (r_dvd[width-1 -: bits_per_cycle]),
    .i_divisor(r_dsr),
    .o_rem    (w_step_rem),
    .o_q      (w_step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.go) w_next = RUN;
      RUN:     if (!bus.go) w_next = IDLE;
               else if (r_cnt == '0) w_next = FIX;
      FIX:     w_next = bus.go ? DONE : IDLE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // With a zero divisor every step subtracts zero, so the partial remainder finishes holding
  // the dividend magnitude; the ordinary remainder sign fix then reproduces left as sampled.
  always_comb begin
    w_fix_r = r_neg_l ? -r_rem[width-1:0] : r_rem[width-1:0];
    w_fix_q = (r_neg_l ^ r_neg_r) ? -r_q : r_q;
    if (r_dz) begin
      w_fix_q = '1;
    end else if (r_ovf) begin
      w_fix_q = MOST_NEG;
      w_fix_r = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_q     <= '0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_neg_l <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.go) begin
          r_dvd   <= w_mag_l;
          r_dsr   <= w_mag_r;
          r_neg_l <= w_neg_l;
          r_neg_r <= w_neg_r;
          r_dz    <= (bus.right == '0);
          r_ovf   <= (signed_mode != 0) && (bus.left == MOST_NEG) && (bus.right == '1);
          r_rem   <= '0;
          r_q     <= '0;
          r_cnt   <= CNT_LAST;
        end
        RUN: begin
          r_rem <= w_step_rem;
          r_dvd <= r_dvd << bits_per_cycle;
          r_q   <= (r_q << bits_per_cycle) | width'(w_step_q);
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: if (bus.go) begin
          r_quo <= w_fix_q;
          r_rmd <= w_fix_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_quotient  = r_quo;
  assign bus.out_remainder = r_rmd;
  assign bus.done          = (r_state == DONE);

`ifdef DIV_SELF_CHECK_EN
  logic [width-1:0] r_chk_l, r_chk_r;
  logic [width-1:0] w_exp_q, w_exp_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chk_l <= '0;
      r_chk_r <= '0;
    end else if (r_state == IDLE && bus.go) begin
      r_chk_l <= bus.left;
      r_chk_r <= bus.right;
    end
  end

  always_comb begin
    w_exp_q = '0;
    w_exp_r = '0;
    if (r_chk_r != '0) begin
      if (signed_mode != 0) begin
        w_exp_q = $signed(r_chk_l) / $signed(r_chk_r);
        w_exp_r = $signed(r_chk_l) % $signed(r_chk_r);
      end else begin
        w_exp_q = r_chk_l / r_chk_r;
        w_exp_r = r_chk_l % r_chk_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && r_state == DONE && !r_dz && !r_ovf &&
        (r_quo != w_exp_q || r_rmd != w_exp_r)) begin
      $error("std_div_radix_pipe self-check: left=%0h right=%0h expected q=%0h r=%0h computed q=%0h r=%0h",
             r_chk_l, r_chk_r, w_exp_q, w_exp_r, r_quo, r_rmd);
    end
  end
`endif

endmodule

// File: tb/tb_std_div_radix_pipe.sv
// Directed bench for std_div_radix_pipe: three instances (8-bit radix-2 unsigned, 8-bit
// radix-4 signed, 32-bit radix-16 signed) with hand-computed expected values, plus a
// back-to-back run on the 32-bit instance against a behavioural / and % model.
module tb_std_div_radix_pipe;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;

  std_div_radix_pipe_if #(.width(8))  ifa ();
  std_div_radix_pipe_if #(.width(8))  ifb ();
  std_div_radix_pipe_if #(.width(32)) ifc ();

  std_div_radix_pipe #(.width(8), .bits_per_cycle(1), .signed_mode(0)) u_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  std_div_radix_pipe #(.width(8), .bits_per_cycle(2), .signed_mode(1)) u_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );
  std_div_radix_pipe #(.width(32), .bits_per_cycle(4), .signed_mode(1)) u_c (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set8(input int sel, input logic g, input logic [7:0] l, input logic [7:0] r);
    if (sel == 0) begin
      ifa.go = g; ifa.left = l; ifa.right = r;
    end else begin
      ifb.go = g; ifb.left = l; ifb.right = r;
    end
  endtask

  // {done, quotient, remainder}
  function automatic logic [16:0] get8(input int sel);
    if (sel == 0) return {ifa.done, ifa.out_quotient, ifa.out_remainder};
    return {ifb.done, ifb.out_quotient, ifb.out_remainder};
  endfunction

  // One full operation on an 8-bit instance; done is expected n_iter+1 edges after the
  // start edge, for exactly one cycle. Operands are scrambled after the start edge.
  task automatic op8(input int sel, input string tag, input logic [7:0] l, input logic [7:0] r,
                     input logic [7:0] eq, input logic [7:0] er, input int n_iter);
    logic [16:0] o;
    int          e;
    bit          seen;
    set8(sel, 1'b1, l, r);
    @(posedge clk); #1;
    set8(sel, 1'b1, ~l, r + 8'd3);
    e    = 0;
    seen = 0;
    o    = '0;
    while (!seen && e < 4 * n_iter + 8) begin
      @(posedge clk); #1;
      e++;
      o    = get8(sel);
      seen = o[16];
    end
    chk_val({tag, "_lat"}, 64'(e), 64'(n_iter + 1));
    chk_val({tag, "_q"}, 64'(o[15:8]), 64'(eq));
    chk_val({tag, "_r"}, 64'(o[7:0]), 64'(er));
    set8(sel, 1'b0, l, r);
    @(posedge clk); #1;
    o = get8(sel);
    chk_val({tag, "_pulse"}, 64'(o[16]), 64'd0);
  endtask

  task automatic model32(input logic [31:0] l, input logic [31:0] r,
                         output logic [31:0] q, output logic [31:0] rm);
    if (r == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      rm = l;
    end else if (l == 32'h8000_0000 && r == 32'hFFFF_FFFF) begin
      q  = l;
      rm = 32'd0;
    end else begin
      q  = $signed(l) / $signed(r);
      rm = $signed(l) % $signed(r);
    end
  endtask

  task automatic pick32(output logic [31:0] l, output logic [31:0] r);
    int k;
    k = $urandom_range(0, 15);
    l = $urandom;
    r = $urandom;
    case (k)
      0: r = 32'd0;
      1: begin l = 32'h8000_0000; r = 32'hFFFF_FFFF; end
      2: r = 32'($urandom_range(1, 20));
      3: r = -32'($urandom_range(1, 20));
      4: l = 32'h8000_0000;
      5: l = 32'd0;
      6, 7, 8, 9: begin
        r = r >> $urandom_range(4, 28);
        if (r == 32'd0) r = 32'd1;
        if ($urandom_range(0, 1) == 1) r = -r;
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [16:0] o;
    bit          seen;
    logic [31:0] l32, r32, eq32, er32;
    int          last, e0, t0;

    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    reset = 1'b1;
    set8(0, 1'b0, 8'd0, 8'd0);
    set8(1, 1'b0, 8'd0, 8'd0);
    ifc.go = 1'b0; ifc.left = '0; ifc.right = '0;
    repeat (3) @(posedge clk);
    #1;
    o = get8(0);
    chk_val("rst_a", 64'(o), 64'd0);
    o = get8(1);
    chk_val("rst_b", 64'(o), 64'd0);
    chk_val("rst_c", {31'd0, ifc.done, ifc.out_quotient}, 64'd0);
    chk_val("rst_c_r", 64'(ifc.out_remainder), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 8-bit unsigned, one bit per cycle (N = 8)
    op8(0, "u_200_7",  8'd200, 8'd7,  8'd28,  8'd4,  8);
    op8(0, "u_255_16", 8'd255, 8'd16, 8'd15,  8'd15, 8);
    op8(0, "u_dz",     8'h5A,  8'h00, 8'hFF,  8'h5A, 8);

    // abort: go dropped during the third RUN cycle
    set8(0, 1'b1, 8'd100, 8'd9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    set8(0, 1'b0, 8'd100, 8'd9);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      o = get8(0);
      if (o[16]) seen = 1;
    end
    chk_val("abort_done", 64'(seen), 64'd0);
    chk_val("abort_q", 64'(o[15:8]), 64'hFF);
    chk_val("abort_r", 64'(o[7:0]), 64'h5A);
    op8(0, "u_9_3", 8'd9, 8'd3, 8'd3, 8'd0, 8);

    // reset while in FIX (start edge + 8 RUN edges)
    set8(0, 1'b1, 8'd50, 8'd5);
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    o = get8(0);
    chk_val("rstfix_out", 64'(o), 64'd0);
    reset = 1'b0;
    set8(0, 1'b0, 8'd50, 8'd5);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      o = get8(0);
      if (o[16]) seen = 1;
    end
    chk_val("rstfix_done", 64'(seen), 64'd0);
    op8(0, "u_17_4", 8'd17, 8'd4, 8'd4, 8'd1, 8);

    // 8-bit signed, two bits per cycle (N = 4)
    op8(1, "s_m7_2",   8'hF9, 8'h02, 8'hFD, 8'hFF, 4);
    op8(1, "s_7_m2",   8'h07, 8'hFE, 8'hFD, 8'h01, 4);
    op8(1, "s_ovf",    8'h80, 8'hFF, 8'h80, 8'h00, 4);
    op8(1, "s_dz",     8'h90, 8'h00, 8'hFF, 8'h90, 4);
    op8(1, "s_m8_m3",  8'hF8, 8'hFD, 8'h02, 8'hFE, 4);
    op8(1, "s_m128_7", 8'h80, 8'h07, 8'hEE, 8'hFE, 4);
    op8(1, "s_127_3",  8'h7F, 8'h03, 8'h2A, 8'h01, 4);

    // 32-bit signed, four bits per cycle (N = 8), back-to-back with go held high
    pick32(l32, r32);
    ifc.left  = l32;
    ifc.right = r32;
    ifc.go    = 1'b1;
    t0   = cyc;
    last = 0;
    for (int i = 0; i < 1000; i++) begin
      seen = 0;
      e0   = cyc;
      while (!seen && (cyc - e0) < 40) begin
        @(posedge clk); #1;
        seen = ifc.done;
      end
      if (!seen) begin
        chk_val("r32_timeout", 64'd0, 64'd1);
        break;
      end
      model32(l32, r32, eq32, er32);
      chk_val("r32_q", 64'(ifc.out_quotient), 64'(eq32));
      chk_val("r32_r", 64'(ifc.out_remainder), 64'(er32));
      if (i == 0) chk_val("r32_lat", 64'(cyc - t0), 64'd10);
      else        chk_val("r32_gap", 64'(cyc - last), 64'd11);
      last = cyc;
      pick32(l32, r32);
      ifc.left  = l32;
      ifc.right = r32;
    end
    ifc.go = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
